// File: rtl/muldiv_unit_if.sv
// Execute-stage bus between the pipeline and the iterative multiply/divide unit.
// The pipeline side uses the master modport; the unit uses the slave modport.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             mthiE;
  logic             mtloE;
  logic             mfE;
  logic             abortE;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stallE;

  modport master (
    output startE, opE, srcaE, srcbE, mthiE, mtloE, mfE, abortE,
    input  hi, lo, busy, done, stallE
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, mthiE, mtloE, mfE, abortE,
    output hi, lo, busy, done, stallE
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply (radix-2 shift-add) / divide (restoring) unit with HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: a multiply finishes once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave mdBus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateT;

  stateT                  state;
  stateT                  stateNext;
  logic [CW-1:0]          count;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]       opB;
  logic                   isDiv;
  logic                   negQ;
  logic                   negR;
  logic                   divZero;
  logic [WIDTH-1:0]       hiR;
  logic [WIDTH-1:0]       loR;
  logic                   doneR;

  logic                   signedOp;
  logic signed [WIDTH-1:0] srcaS;
  logic signed [WIDTH-1:0] srcbS;
  logic [WIDTH-1:0]       magA;
  logic [WIDTH-1:0]       magB;
  logic [WIDTH:0]         remCat;
  logic [WIDTH:0]         trial;
  logic                   qBit;
  logic [WIDTH-1:0]       newRem;
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       hiRes;
  logic [WIDTH-1:0]       loRes;
  logic                   lastIter;
  logic                   startAcc;
  logic                   resWr;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic isSigned);
    logic [WIDTH-1:0] r;
    r = v;
    if (isSigned && v[WIDTH-1]) r = -r;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] applySignWide(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    signedOp = ~mdBus.opE[0];
    srcaS    = mdBus.srcaE;
    srcbS    = mdBus.srcbE;
    magA     = magnitude(srcaS, signedOp);
    magB     = magnitude(srcbS, signedOp);

    // Restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    // A zero divisor leaves the remainder shifting in the dividend, so HI ends as |dividend|.
    remCat = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial  = remCat - {1'b0, opB};
    qBit   = ~trial[WIDTH];
    newRem = qBit ? trial[WIDTH-1:0] : remCat[WIDTH-1:0];

    prod = applySignWide(acc, negQ);
    if (isDiv) begin
      hiRes = applySign(acc[2*WIDTH-1:WIDTH], negR);
      loRes = divZero ? {WIDTH{1'b1}} : applySign(acc[WIDTH-1:0], negQ);
    end else begin
      hiRes = prod[2*WIDTH-1:WIDTH];
      loRes = prod[WIDTH-1:0];
    end

    lastIter = (count == '0);
`ifdef MULDIV_EARLY_OUT_EN
    if (!isDiv && (opB[WIDTH-1:1] == '0)) lastIter = 1'b1;
`else
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    startAcc  = 1'b0;
    resWr     = 1'b0;
    case (state)
      IDLE: begin
        if (mdBus.startE && !mdBus.abortE) begin
          startAcc  = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (mdBus.abortE)  stateNext = IDLE;
        else if (lastIter) stateNext = FIX;
      end
      FIX: begin
        stateNext = IDLE;
        resWr     = !mdBus.abortE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand capture and one iteration per RUN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      opB     <= '0;
      isDiv   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
    end else if (startAcc) begin
      isDiv   <= mdBus.opE[1];
      negQ    <= signedOp & (mdBus.srcaE[WIDTH-1] ^ mdBus.srcbE[WIDTH-1]);
      negR    <= signedOp & mdBus.srcaE[WIDTH-1];
      divZero <= (mdBus.srcbE == '0);
      opB     <= magB;
      mcand   <= {{WIDTH{1'b0}}, magA};
      acc     <= mdBus.opE[1] ? {{WIDTH{1'b0}}, magA} : '0;
      count   <= CW'(WIDTH - 1);
    end else if (state == RUN && !mdBus.abortE) begin
      count <= count - CW'(1);
      if (isDiv) begin
        acc <= {newRem, acc[WIDTH-2:0], qBit};
      end else begin
        if (opB[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        opB   <= opB >> 1;
      end
    end
  end

  // Architectural HI/LO: results from FIX, otherwise mthi/mtlo only while idle and not starting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hiR   <= '0;
      loR   <= '0;
      doneR <= 1'b0;
    end else begin
      doneR <= resWr;
      if (resWr) begin
        hiR <= hiRes;
        loR <= loRes;
      end else if (state == IDLE && !mdBus.startE) begin
        if (mdBus.mthiE) hiR <= mdBus.srcaE;
        if (mdBus.mtloE) loR <= mdBus.srcaE;
      end
    end
  end

  assign mdBus.hi     = hiR;
  assign mdBus.lo     = loR;
  assign mdBus.done   = doneR;
  assign mdBus.busy   = (state != IDLE);
  assign mdBus.stallE = mdBus.busy & (mdBus.startE | mdBus.mfE | mdBus.mthiE | mdBus.mtloE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes reference results, a monitor checks them on done.
module tb_muldiv_unit;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } resT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  resT  expQ[$];
  resT  monE;
  int   nCmp = 0;
  int   nFail = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) mdBus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .mdBus (mdBus)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero with dividend-signed remainder.
  function automatic resT model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    resT         r;
    longint      sa, sb, q, rm;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.hi = '0;
    r.lo = '0;
    case (op)
      2'd0: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'd2: begin
        if (b == '0) begin r.hi = a; r.lo = '1; end
        else begin q = sa / sb; rm = sa % sb; r.lo = q[31:0]; r.hi = rm[31:0]; end
      end
      default: begin
        if (b == '0) begin r.hi = a; r.lo = '1; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // Called #1 after an edge; the edge inside is "edge 0" and we return #1 after it.
  task automatic startOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit expectDone);
    mdBus.opE    = op;
    mdBus.srcaE  = a;
    mdBus.srcbE  = b;
    mdBus.startE = 1'b1;
    if (expectDone) expQ.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    mdBus.startE = 1'b0;
  endtask

  task automatic mtWrite(input logic wHi, input logic wLo, input logic [W-1:0] v);
    mdBus.mthiE = wHi;
    mdBus.mtloE = wLo;
    mdBus.srcaE = v;
    @(posedge clk);
    #1;
    mdBus.mthiE = 1'b0;
    mdBus.mtloE = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (mdBus.busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (mdBus.busy) begin
      nCmp++;
      nFail++;
      $display("FAIL busy timeout: busy still %b after %0d cycles, expected 0", mdBus.busy, n);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && mdBus.done) begin
      if (expQ.size() == 0) begin
        nCmp++;
        nFail++;
        $display("FAIL unexpected done: got done=1, expected no pending result");
      end else begin
        monE = expQ.pop_front();
        check("result hi", mdBus.hi, monE.hi);
        check("result lo", mdBus.lo, monE.lo);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a, b;
    mdBus.startE = 1'b0;
    mdBus.opE    = 2'd0;
    mdBus.srcaE  = '0;
    mdBus.srcbE  = '0;
    mdBus.mthiE  = 1'b0;
    mdBus.mtloE  = 1'b0;
    mdBus.mfE    = 1'b0;
    mdBus.abortE = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset hi", mdBus.hi, '0);
    check("reset lo", mdBus.lo, '0);
    check("reset busy", W'(mdBus.busy), '0);
    check("reset done", W'(mdBus.done), '0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // multu max x max with exact latency
    startOp(2'd1, '1, '1, 1'b1);
    repeat (32) @(posedge clk);
    @(negedge clk);
    check("busy at edge 32", W'(mdBus.busy), W'(1));
    @(negedge clk);
    check("edge33 hi", mdBus.hi, 32'hFFFF_FFFE);
    check("edge33 lo", mdBus.lo, 32'h0000_0001);
    check("edge33 done", W'(mdBus.done), W'(1));
    @(negedge clk);
    check("edge34 busy", W'(mdBus.busy), '0);
    check("edge34 done", W'(mdBus.done), '0);
    @(posedge clk);
    #1;

    startOp(2'd0, -32'sd3, 32'sd7, 1'b1);
    waitIdle();
    startOp(2'd2, -32'sd7, 32'sd2, 1'b1);
    waitIdle();
    startOp(2'd3, 32'h0000_1234, '0, 1'b1);
    waitIdle();
    startOp(2'd2, 32'h8000_0000, '1, 1'b1);
    waitIdle();
    startOp(2'd2, 32'hFFFF_FF00, '0, 1'b1);
    waitIdle();

    // mthi, then mf/mtlo held off while busy
    mtWrite(1'b1, 1'b0, 32'hA5A5_A5A5);
    check("mthi hi", mdBus.hi, 32'hA5A5_A5A5);
    mdBus.mfE = 1'b1;
    #1;
    check("idle stallE", W'(mdBus.stallE), '0);
    mdBus.mfE = 1'b0;
    startOp(2'd1, 32'd2, 32'd3, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    mdBus.mfE   = 1'b1;
    mdBus.mtloE = 1'b1;
    mdBus.srcaE = 32'hDEAD_BEEF;
    @(negedge clk);
    check("busy stallE", W'(mdBus.stallE), W'(1));
    repeat (16) @(posedge clk);
    #1;
    check("busy stallE late", W'(mdBus.stallE), W'(1));
    mdBus.mfE   = 1'b0;
    mdBus.mtloE = 1'b0;
    waitIdle();
    check("after mt hi", mdBus.hi, '0);
    check("after mt lo", mdBus.lo, 32'd6);

    // start together with mthi: start wins
    mtWrite(1'b1, 1'b0, 32'h55);
    mdBus.mthiE = 1'b1;
    startOp(2'd1, 32'd4, 32'd4, 1'b1);
    mdBus.mthiE = 1'b0;
    check("start over mthi", mdBus.hi, 32'h55);
    waitIdle();

    // abort mid-run
    mtWrite(1'b1, 1'b0, 32'h11);
    mtWrite(1'b0, 1'b1, 32'h22);
    startOp(2'd0, 32'd5, 32'd5, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    mdBus.abortE = 1'b1;
    @(posedge clk);
    #1;
    mdBus.abortE = 1'b0;
    check("abort busy", W'(mdBus.busy), '0);
    repeat (40) @(posedge clk);
    #1;
    check("abort hi", mdBus.hi, 32'h11);
    check("abort lo", mdBus.lo, 32'h22);
    startOp(2'd1, 32'd9, 32'd9, 1'b1);
    waitIdle();

    // asynchronous reset mid-run
    startOp(2'd3, 32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async reset hi", mdBus.hi, '0);
    check("async reset lo", mdBus.lo, '0);
    check("async reset busy", W'(mdBus.busy), '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    startOp(2'd1, 32'd7, 32'd1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
`ifdef MULDIV_EARLY_OUT_EN
    check("early lo at edge 2", mdBus.lo, 32'd7);
    check("early busy at edge 2", W'(mdBus.busy), '0);
`else
    check("full latency busy at edge 2", W'(mdBus.busy), W'(1));
`endif
    waitIdle();

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      startOp(op, a, b, 1'b1);
      waitIdle();
    end

    check("scoreboard drained", W'(expQ.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
